// File: rtl/mixcol_seq.sv
// mixcol_seq: AES MixColumns engine that transforms CPC columns per cycle in place.
// Define MIXCOL_INV_EN to build the InvMixColumns datapath selected by the captured inv bit.
module mixcol_seq #(
    parameter int NB  = 4,
    parameter int CPC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NB*32-1:0] in_state,
    input  logic            enbmc,
    input  logic            inv,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NB*32-1:0] out_state
);
    localparam int W  = NB * 32;
    localparam int CW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

    fsm_e          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          enbmc_q, enbmc_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4]
                           ^ a[(i+2)%4] ^ a[(i+3)%4];
        end
        return r;
    endfunction

`ifdef MIXCOL_INV_EN
    logic inv_q, inv_d;

    // Coefficients 0E/0B/0D/09 built from the x2/x4/x8 multiples of each byte.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0]  a [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                           ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                           ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                           ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
        end
        return r;
    endfunction
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic [31:0] col;
        logic [31:0] res;
        int          base;
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        enbmc_d   = enbmc_q;
`ifdef MIXCOL_INV_EN
        inv_d     = inv_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        col       = '0;
        res       = '0;
        base      = 0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_state;
                    enbmc_d = enbmc;
`ifdef MIXCOL_INV_EN
                    inv_d   = inv;
`endif
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < CPC; j++) begin
                    base = W - 1 - 32 * (int'(cnt_q) + j);
                    col  = data_q[base -: 32];
`ifdef MIXCOL_INV_EN
                    res  = inv_q ? mix_inv(col) : mix_fwd(col);
`else
                    res  = mix_fwd(col);
`endif
                    // Pass-through still occupies the column slot so latency is mode-independent.
                    data_d[base -: 32] = enbmc_q ? res : col;
                end
                cnt_d = cnt_q + CW'(CPC);
                if (int'(cnt_q) == NB - CPC) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the state register is reset too, so out_state reads zero straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            enbmc_q <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            enbmc_q <= enbmc_d;
`ifdef MIXCOL_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign out_state = data_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// Self-checking bench for mixcol_seq: directed and random states against a GF(2^8) matrix model.
module tb_mixcol_seq;
    localparam int W = 128;
`ifdef MIXCOL_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, enbmc, inv, out_valid, out_ready;
    logic [W-1:0] in_state, out_state;
    logic         in_valid4, in_ready4, out_valid4, out_ready4;
    logic [W-1:0] in_state4, out_state4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mixcol_seq #(.NB(4), .CPC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_state(in_state), .enbmc(enbmc), .inv(inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_state(out_state)
    );

    mixcol_seq #(.NB(4), .CPC(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_state(in_state4), .enbmc(1'b1), .inv(1'b0), .out_valid(out_valid4),
        .out_ready(out_ready4), .out_state(out_state4)
    );

    // Generic shift-and-add multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = int'(a);
        int y = int'(b);
        for (int i = 0; i < 8; i++) begin
            if ((y & 1) != 0) p = p ^ x;
            y = y >> 1;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return 8'(p);
    endfunction

    // Each column times the circulant matrix whose first row is cf.
    function automatic logic [W-1:0] model(input logic [W-1:0] st, input logic en, input logic iv);
        logic [7:0]   cf [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [W-1:0] r;
        if (!en) return st;
        if (iv && INV_EN) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else              cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = st[W-1-32*c-8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(cf[(k - row + 4) % 4], a[k]);
                r[W-1-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; leaves the bench at the falling edge after release.
    task automatic txn(input string tag, input logic [W-1:0] st, input logic en, input logic iv,
                       input logic [W-1:0] exp);
        int lat;
        check({tag, " in_ready"}, W'(in_ready), W'(1));
        in_state = st; enbmc = en; inv = iv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_state = rnd_state(); enbmc = ~en; inv = ~iv;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, W'(lat), W'(4));
        check({tag, " data"}, out_state, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " release"}, W'({out_valid, in_ready}), W'(2'b01));
    endtask

    initial begin
        logic [W-1:0] vec, exp, st;
        logic [W-1:0] sts [3];
        int lat, got, nacc;
        int acc_cyc [3];

        rst = 1'b1; in_valid = 1'b0; in_state = '0; enbmc = 1'b0; inv = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_state4 = '0; out_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset out_state", out_state, '0);
        check("reset4 out_valid", W'(out_valid4), W'(0));

        // Known forward vector, checked against literal columns.
        vec = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        txn("fwd vector", vec, 1'b1, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

        for (int i = 0; i < 4; i++) begin
            st = rnd_state();
            txn("fwd random", st, 1'b1, 1'b0, model(st, 1'b1, 1'b0));
        end
        for (int i = 0; i < 2; i++) begin
            st = rnd_state();
            txn("bypass random", st, 1'b0, $urandom_range(0, 1) == 1, st);
        end

`ifdef MIXCOL_INV_EN
        vec = 128'h8e4da1bc_9fdc589d_d4d4d4d5_2d26314c;
        txn("inv vector", vec, 1'b1, 1'b1, model(vec, 1'b1, 1'b1));
        check("inv vector cols01", W'(out_state[127:64]), W'(64'hdb135345_f20a225c));
        st = rnd_state();
        txn("inv random", st, 1'b1, 1'b1, model(st, 1'b1, 1'b1));
`else
        txn("inv ignored", vec, 1'b1, 1'b1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
`endif

        // Four columns per cycle: result one cycle after acceptance.
        check("cpc4 in_ready", W'(in_ready4), W'(1));
        in_state4 = vec; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0; in_state4 = rnd_state();
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("cpc4 latency", W'(lat), W'(1));
        check("cpc4 data", out_state4, model(vec, 1'b1, 1'b0));
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check("cpc4 release", W'({out_valid4, in_ready4}), W'(2'b01));

        // Consumer stalls for 10 cycles while a producer pushes a new state.
        st = rnd_state();
        exp = model(st, 1'b1, 1'b0);
        in_state = st; enbmc = 1'b1; inv = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall latency", W'(lat), W'(4));
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_state = rnd_state();
            @(negedge clk);
            check("stall hold", W'({out_valid, in_ready}), W'(2'b10));
            check("stall data", out_state, exp);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stall release", W'({out_valid, in_ready}), W'(2'b01));
        @(negedge clk);
        check("stall no accept", W'({out_valid, in_ready}), W'(2'b01));

        // Reset pulse with two columns already written.
        in_state = rnd_state(); enbmc = 1'b1; inv = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midbusy rst out_valid", W'(out_valid), W'(0));
        check("midbusy rst out_state", out_state, '0);
        check("midbusy rst in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        rst = 1'b0;
        txn("post reset", {4{32'hd4bf5d30}}, 1'b1, 1'b0, {4{32'h046681e5}});

        // Back-to-back states with the consumer always ready.
        for (int i = 0; i < 3; i++) sts[i] = rnd_state();
        got = 0; nacc = 0;
        out_ready = 1'b1; enbmc = 1'b1; inv = 1'b0;
        in_state = sts[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            if (out_valid) begin
                check("b2b data", out_state, model(sts[got], 1'b1, 1'b0));
                got++;
            end
            if (in_valid && in_ready && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
            in_valid = (nacc < 3);
            if (nacc < 3) in_state = sts[nacc];
        end
        out_ready = 1'b0; in_valid = 1'b0;
        check("b2b results", W'(got), W'(3));
        check("b2b accepts", W'(nacc), W'(3));
        check("b2b spacing01", W'((nacc >= 2) ? acc_cyc[1] - acc_cyc[0] : -1), W'(6));
        check("b2b spacing12", W'((nacc >= 3) ? acc_cyc[2] - acc_cyc[1] : -1), W'(6));
        repeat (3) @(negedge clk);
        check("b2b no duplicate", W'({out_valid, in_ready}), W'(2'b01));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
